// File: rtl/fs_pkg.sv
// Shared constants for the full subtractor slice.
// Counter width default and the saturation ceiling source.
package fs_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // Sliced down to CNT_W bits to form the all-ones ceiling.
  localparam logic [63:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/fs_cell.sv
// Single-bit combinational full subtractor cell.
// diff = a ^ b ^ bin; bout from the borrow equation.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign diff = ab_x ^ bin;
  assign bout = (~a & b) | (~ab_x & bin);

endmodule

// File: rtl/full_subtractor.sv
// Full subtractor with registered result and
// saturating operation / borrow statistics counters.
module full_subtractor
  import fs_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             a,
  input  logic             b,
  input  logic             bin,
  output logic             diff,
  output logic             bout,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             diff_q,
  output logic             bout_q,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] brw_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_SAT_ALL[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic             dr_q, dr_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] bw_q, bw_d;

  fs_cell u_cell (
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout)
  );

  always_comb begin
    dr_d = dr_q;
    br_d = br_q;
    op_d = op_q;
    bw_d = bw_q;
    if (en) begin
      dr_d = diff;
      br_d = bout;
      if (op_q != CNT_MAX)
        op_d = op_q + CNT_ONE;
      // brw only moves with op, so it never overtakes it
      if (bout && bw_q != CNT_MAX)
        bw_d = bw_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_q <= 1'b0;
      br_q <= 1'b0;
      op_q <= '0;
      bw_q <= '0;
    end else begin
      dr_q <= dr_d;
      br_q <= br_d;
      op_q <= op_d;
      bw_q <= bw_d;
    end
  end

  assign diff_q  = dr_q;
  assign bout_q  = br_q;
  assign op_cnt  = op_q;
  assign brw_cnt = bw_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: directed steps plus random
// traffic against an arithmetic reference model.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, bin = 1'b0, en = 1'b0;

  logic       d8, bo8, dq8, bq8;
  logic       d4, bo4, dq4, bq4;
  logic [7:0] op8, bw8;
  logic [3:0] op4, bw4;

  int tests = 0;
  int fails = 0;

  int n_op = 0;
  int n_brw = 0;
  logic md = 1'b0, mb = 1'b0;

  logic [1:0] tbl [8];

  always #5 clk = ~clk;

  full_subtractor #(.CNT_W(8)) u8 (
    .a(a), .b(b), .bin(bin), .diff(d8), .bout(bo8),
    .clk(clk), .rst_n(rst_n), .en(en),
    .diff_q(dq8), .bout_q(bq8),
    .op_cnt(op8), .brw_cnt(bw8)
  );

  full_subtractor #(.CNT_W(4)) u4 (
    .a(a), .b(b), .bin(bin), .diff(d4), .bout(bo4),
    .clk(clk), .rst_n(rst_n), .en(en),
    .diff_q(dq4), .bout_q(bq4),
    .op_cnt(op4), .brw_cnt(bw4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: a - b - bin in plain integers.
  task automatic ref_sub(output logic d, output logic bo);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    d = r[0];
    bo = (r < 0);
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_comb(input string tag);
    logic d, bo;
    ref_sub(d, bo);
    chk({tag, ".diff8"}, 32'(d8), 32'(d));
    chk({tag, ".bout8"}, 32'(bo8), 32'(bo));
    chk({tag, ".diff4"}, 32'(d4), 32'(d));
    chk({tag, ".bout4"}, 32'(bo4), 32'(bo));
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".dq8"}, 32'(dq8), 32'(md));
    chk({tag, ".bq8"}, 32'(bq8), 32'(mb));
    chk({tag, ".op8"}, 32'(op8), 32'(sat(n_op, 8)));
    chk({tag, ".bw8"}, 32'(bw8), 32'(sat(n_brw, 8)));
    chk({tag, ".dq4"}, 32'(dq4), 32'(md));
    chk({tag, ".bq4"}, 32'(bq4), 32'(mb));
    chk({tag, ".op4"}, 32'(op4), 32'(sat(n_op, 4)));
    chk({tag, ".bw4"}, 32'(bw4), 32'(sat(n_brw, 4)));
  endtask

  task automatic model_reset();
    n_op = 0;
    n_brw = 0;
    md = 1'b0;
    mb = 1'b0;
  endtask

  // One rising edge; model follows, then settle to negedge.
  task automatic tick();
    logic d, bo;
    @(posedge clk);
    if (rst_n && en) begin
      ref_sub(d, bo);
      md = d;
      mb = bo;
      n_op++;
      if (bo) n_brw++;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01,
            2'b10, 2'b00, 2'b00, 2'b11};

    #1;
    chk_regs("reset");

    // Exhaustive truth table, held in reset.
    for (int i = 0; i < 8; i++) begin
      {a, b, bin} = 3'(i);
      #1;
      chk($sformatf("tt%0d.diff", i), 32'(d8),
          32'(tbl[i][1]));
      chk($sformatf("tt%0d.bout", i), 32'(bo8),
          32'(tbl[i][0]));
      chk_comb($sformatf("tt%0d", i));
      #9;
    end
    chk_regs("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    {a, b, bin} = 3'b100;
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_regs("en0_hold");

    {a, b, bin} = 3'b011;
    en = 1'b1;
    tick();
    chk(" one.dq", 32'(dq8), 32'd0);
    chk("one.bq", 32'(bq8), 32'd1);
    chk("one.op", 32'(op8), 32'd1);
    chk("one.bw", 32'(bw8), 32'd1);
    chk_regs("one");

    for (int i = 0; i < 200; i++) begin
      {a, b, bin} = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) != 0);
      #1;
      chk_comb("rnd");
      tick();
      chk_regs("rnd");
      assert (bw8 <= op8) else begin
        fails++;
        $error("FAIL brw_le_op: brw %0d op %0d", bw8, op8);
      end
      tests++;
    end

    // Asynchronous reset pulse between edges.
    model_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {a, b, bin} = 3'($urandom_range(0, 7));
      tick();
    end
    chk_regs("pre_pulse");
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_regs("pulse");
    chk_comb("pulse");
    #1;
    rst_n = 1'b1;
    {a, b, bin} = 3'b001;
    tick();
    chk_regs("post_pulse");

    // Reset held across an edge beats en.
    rst_n = 1'b0;
    model_reset();
    {a, b, bin} = 3'b010;
    tick();
    chk_regs("rst_prio");

    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat.op4", 32'(op4), 32'd15);
    chk("sat.bw4", 32'(bw4), 32'd15);
    chk("sat.op8", 32'(op8), 32'd20);
    chk_regs("sat");

    {a, b, bin} = 3'b100;
    tick();
    chk("sat_upd.dq4", 32'(dq4), 32'd1);
    chk("sat_upd.bq4", 32'(bq4), 32'd0);
    chk_regs("sat_upd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the statistics counters.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; registered logic updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port a, input, 1 bit: minuend bit.
REQ-005 SHALL have port b, input, 1 bit: subtrahend bit.
REQ-006 SHALL have port bin, input, 1 bit: borrow-in.
REQ-007 SHALL have port diff, output, 1 bit: combinational difference.
REQ-008 SHALL have port bout, output, 1 bit: combinational borrow-out.
REQ-009 SHALL have port en, input, 1 bit: sample strobe for the registered path.
REQ-010 SHALL have port diff_q, output, 1 bit: registered diff.
REQ-011 SHALL have port bout_q, output, 1 bit: registered bout.
REQ-012 SHALL have port op_cnt, output, CNT_W bits: number of sampled operations.
REQ-013 SHALL have port brw_cnt, output, CNT_W bits: number of sampled operations with bout=1.
REQ-014 SHALL declare ports in the order a, b, bin, diff, bout, clk, rst_n, en, diff_q, bout_q, op_cnt, brw_cnt, so that a positional 5-port instance of (a, b, bin, diff, bout) is legal; unconnected clk, rst_n and en are permitted.

Function
REQ-015 SHALL compute diff = a XOR b XOR bin, purely combinationally with zero latency.
REQ-016 SHALL compute bout = (NOT a AND b) OR (NOT(a XOR b) AND bin), purely combinationally with zero latency.
REQ-017 SHALL produce these (diff, bout) values for (a, b, bin): 000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.
REQ-018 SHALL keep diff and bout independent of clk, rst_n and en, including while rst_n=0.
REQ-019 SHALL, on a rising clk edge with en=1, load diff_q<=diff and bout_q<=bout, giving 1-cycle latency.
REQ-020 SHALL, on a rising clk edge with en=0, hold diff_q, bout_q, op_cnt and brw_cnt.
REQ-021 SHALL, on a rising clk edge with en=1, increment op_cnt by 1, saturating at all-ones (no wrap).
REQ-022 SHALL, on a rising clk edge with en=1 and bout=1, increment brw_cnt by 1, saturating at all-ones; brw_cnt SHALL never exceed op_cnt.
REQ-023 SHALL keep each counter at all-ones once saturated, and SHALL still update diff_q and bout_q when en=1.
REQ-024 SHALL be a pure datapath with no handshake and no state machine.

Reset
REQ-025 SHALL, when rst_n=0, immediately clear diff_q, bout_q, op_cnt and brw_cnt to 0, independent of clk.
REQ-026 SHALL, when rst_n is asserted mid-operation, discard any sample pending on the same edge, with reset taking priority over en.
REQ-027 SHALL, on the first rising edge after rst_n deasserts with en=1, sample normally.

Structure
REQ-028 SHALL implement the combinational cell as sub-module fs_cell(a, b, bin, diff, bout), instantiated once.
REQ-029 SHALL place the CNT_W default and a counter-saturation constant in shared package fs_pkg; no typedefs are needed.

Verification
REQ-030 SHALL apply all 8 (a, b, bin) combinations in binary order at 10-time-unit spacing -> diff and bout match REQ-017 at each step.
REQ-031 SHALL apply a=0, b=1, bin=1 with en=1 for one edge -> diff_q=0, bout_q=1, op_cnt=1, brw_cnt=1.
REQ-032 SHALL apply a=1, b=0, bin=0 with en=0 for 5 edges -> all registered outputs remain at their reset value of 0.
REQ-033 SHALL apply CNT_W=4 with en=1 and a=0, b=1, bin=0 for 20 edges -> op_cnt=15 and brw_cnt=15, both saturated.
REQ-034 SHALL pulse rst_n low between clock edges after 3 sampled operations -> all registered outputs read 0 immediately while diff and bout remain valid.
